// File: rtl/sha_round_state_if.sv
// Handshake/data bundle for sha_round_state.
// Master drives control and round terms; slave returns working variables.
interface sha_round_state_if #(
  parameter int DATA_W = 32
) ();
  logic              run;
  logic              load;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] t1;
  logic [DATA_W-1:0] maj;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic [DATA_W-1:0] out4;
  logic [DATA_W-1:0] out5;
  logic [DATA_W-1:0] out6;
  logic [DATA_W-1:0] out7;
  logic [5:0]        round;
  logic              busy;
  logic              done;

  modport master (
    output run, load, init_word, t1, maj,
    input  out0, out1, out2, out3,
    input  out4, out5, out6, out7,
    input  round, busy, done
  );

  modport slave (
    input  run, load, init_word, t1, maj,
    output out0, out1, out2, out3,
    output out4, out5, out6, out7,
    output round, busy, done
  );
endinterface

// File: rtl/sha_round_state.sv
// SHA-256 round state register file with round FSM.
// Optional feed-forward hash registers: define SHA_FEEDFORWARD_EN.
module sha_round_state #(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 64
) (
  input logic           clk,
  input logic           rst,
  sha_round_state_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
`ifdef SHA_FEEDFORWARD_EN
    FEED  = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] wv [8];
  logic [5:0]        round;
  logic              last;
  logic [DATA_W-1:0] s0;
`ifdef SHA_FEEDFORWARD_EN
  logic [DATA_W-1:0] hr [8];
`endif

  function automatic logic [DATA_W-1:0] rotr(
    input logic [DATA_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  assign last = (round == 6'(ROUNDS - 1));
  assign s0   = rotr(wv[0], 2)
              ^ rotr(wv[0], 13)
              ^ rotr(wv[0], 22);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (bus.run && !bus.load) state_nx = ROUND;
      ROUND:
`ifdef SHA_FEEDFORWARD_EN
        if (last) state_nx = FEED;
      FEED:
        state_nx = DONE;
`else
        if (last) state_nx = DONE;
`endif
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ROUND: bus.busy = 1'b1;
`ifdef SHA_FEEDFORWARD_EN
      FEED:  bus.busy = 1'b1;
`endif
      DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Working variables, round counter and optional hash registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        wv[i] <= '0;
`ifdef SHA_FEEDFORWARD_EN
        hr[i] <= '0;
`endif
      end
      round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            wv[0] <= bus.init_word;
            for (int i = 1; i < 8; i++)
              wv[i] <= wv[i-1];
`ifdef SHA_FEEDFORWARD_EN
            hr[0] <= bus.init_word;
            for (int i = 1; i < 8; i++)
              hr[i] <= hr[i-1];
`endif
          end
        end
        ROUND: begin
          wv[0] <= bus.t1 + s0 + bus.maj;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + bus.t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          round <= last ? 6'd0 : round + 6'd1;
        end
`ifdef SHA_FEEDFORWARD_EN
        FEED: begin
          for (int i = 0; i < 8; i++) begin
            wv[i] <= wv[i] + hr[i];
            hr[i] <= wv[i] + hr[i];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.out0  = wv[0];
  assign bus.out1  = wv[1];
  assign bus.out2  = wv[2];
  assign bus.out3  = wv[3];
  assign bus.out4  = wv[4];
  assign bus.out5  = wv[5];
  assign bus.out6  = wv[6];
  assign bus.out7  = wv[7];
  assign bus.round = round;

endmodule

// File: tb/tb_sha_round_state.sv
// Directed bench for sha_round_state using the SHA-256 "abc" block.
// Expected digest accounts for SHA_FEEDFORWARD_EN when defined.
module tb_sha_round_state;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_round_state_if #(.DATA_W(32)) bus ();

  sha_round_state #(
    .DATA_W(32),
    .ROUNDS(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] outs [8];
  always_comb begin
    outs[0] = bus.out0;
    outs[1] = bus.out1;
    outs[2] = bus.out2;
    outs[3] = bus.out3;
    outs[4] = bus.out4;
    outs[5] = bus.out5;
    outs[6] = bus.out6;
    outs[7] = bus.out7;
  end

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] DIG [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic [31:0] W [64];
  logic [31:0] m [8];
  logic [31:0] expv [8];
  logic [31:0] t1v;
  logic [31:0] majv;
  logic [31:0] na;
  logic [31:0] ne;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv();
    for (int i = 7; i >= 0; i--) begin
      bus.load = 1'b1;
      bus.init_word = IV[i];
      step();
    end
    bus.load = 1'b0;
  endtask

  task automatic drive_round(input int r);
    t1v = m[7] + bsig1(m[4]) + ((m[4] & m[5]) ^ (~m[4] & m[6]))
        + K[r] + W[r];
    majv = (m[0] & m[1]) ^ (m[0] & m[2]) ^ (m[1] & m[2]);
    bus.t1 = t1v;
    bus.maj = majv;
  endtask

  task automatic model_update();
    na = t1v + bsig0(m[0]) + majv;
    ne = m[3] + t1v;
    for (int i = 7; i > 0; i--) m[i] = m[i-1];
    m[0] = na;
    m[4] = ne;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (outs[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_out%0d: got %h expected 0", i, outs[i]);
      end
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.round} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b round=%0d expected 0",
               bus.busy, bus.done, bus.round);
    end
    #2 rst = 1'b0;
    bus.load = 1'b1;
    bus.init_word = 32'hdeadbeef;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (outs[0] !== 32'hdeadbeef) begin
      n_fail++;
      $display("FAIL single_load: got %h expected deadbeef", outs[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs[0] !== 32'h0 || outs[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got out0=%h out1=%h expected 0",
               outs[0], outs[1]);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_load_iv();
    load_iv();
    n_checks++;
    if (outs[0] !== 32'h6a09e667) begin
      n_fail++;
      $display("FAIL iv_out0: got %h expected 6a09e667", outs[0]);
    end
    n_checks++;
    if (outs[3] !== 32'ha54ff53a) begin
      n_fail++;
      $display("FAIL iv_out3: got %h expected a54ff53a", outs[3]);
    end
    n_checks++;
    if (outs[7] !== 32'h5be0cd19) begin
      n_fail++;
      $display("FAIL iv_out7: got %h expected 5be0cd19", outs[7]);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL iv_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_one_round();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.round !== 6'd0) begin
      n_fail++;
      $display("FAIL start: got busy=%b round=%0d expected 1 0",
               bus.busy, bus.round);
    end
    for (int i = 0; i < 8; i++) m[i] = IV[i];
    drive_round(0);
    step();
    n_checks++;
    if (outs[0] !== 32'h5d6aebcd) begin
      n_fail++;
      $display("FAIL r0_out0: got %h expected 5d6aebcd", outs[0]);
    end
    n_checks++;
    if (outs[1] !== 32'h6a09e667) begin
      n_fail++;
      $display("FAIL r0_out1: got %h expected 6a09e667", outs[1]);
    end
    n_checks++;
    if (outs[4] !== 32'hfa2a4622) begin
      n_fail++;
      $display("FAIL r0_out4: got %h expected fa2a4622", outs[4]);
    end
    n_checks++;
    if (outs[7] !== 32'h1f83d9ab) begin
      n_fail++;
      $display("FAIL r0_out7: got %h expected 1f83d9ab", outs[7]);
    end
    n_checks++;
    if (bus.round !== 6'd1) begin
      n_fail++;
      $display("FAIL r0_round: got %0d expected 1", bus.round);
    end
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic run_block(input bit inject, input int abort_at);
    load_iv();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = IV[i];
    for (int r = 0; r < 64; r++) begin
      if (r == abort_at) begin
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (outs[0] !== 32'h0 || bus.busy !== 1'b0 || bus.round !== 6'd0) begin
          n_fail++;
          $display("FAIL abort_reset: got out0=%h busy=%b round=%0d expected 0",
                   outs[0], bus.busy, bus.round);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 70; c++) begin
          step();
          n_checks++;
          if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got done=%b busy=%b expected 0 0",
                     bus.done, bus.busy);
          end
        end
        return;
      end
      bus.run = (inject && r == 5);
      bus.load = (inject && r == 5);
      bus.init_word = 32'hffffffff;
      drive_round(r);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.round !== 6'(r)) begin
        n_fail++;
        $display("FAIL round_ctrl: got busy=%b done=%b round=%0d expected 1 0 %0d",
                 bus.busy, bus.done, bus.round, r);
      end
      step();
      model_update();
    end
    bus.run = 1'b0;
    bus.load = 1'b0;
`ifdef SHA_FEEDFORWARD_EN
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL feed_ctrl: got busy=%b done=%b expected 1 0",
               bus.busy, bus.done);
    end
    step();
`endif
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.round !== 6'd0) begin
      n_fail++;
      $display("FAIL done_ctrl: got done=%b busy=%b round=%0d expected 1 0 0",
               bus.done, bus.busy, bus.round);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (outs[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL digest_out%0d: got %h expected %h", i, outs[i], expv[i]);
      end
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || outs[0] !== expv[0]) begin
      n_fail++;
      $display("FAIL after_done: got done=%b busy=%b out0=%h expected 0 0 %h",
               bus.done, bus.busy, outs[0], expv[0]);
    end
  endtask

  task automatic test_full_block();
    run_block(1'b0, -1);
  endtask

  task automatic test_ignore_busy();
    run_block(1'b1, -1);
    for (int i = 7; i >= 1; i--) begin
      bus.load = 1'b1;
      bus.init_word = IV[i];
      step();
    end
    bus.load = 1'b1;
    bus.run = 1'b1;
    bus.init_word = IV[0];
    step();
    bus.load = 1'b0;
    bus.run = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || outs[0] !== IV[0] || outs[7] !== IV[7]) begin
      n_fail++;
      $display("FAIL idle_run_load: got busy=%b out0=%h out7=%h expected 0 %h %h",
               bus.busy, outs[0], outs[7], IV[0], IV[7]);
    end
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_run_load_hold: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    run_block(1'b0, 10);
    run_block(1'b0, -1);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.load = 1'b0;
    bus.init_word = '0;
    bus.t1 = '0;
    bus.maj = '0;
    for (int t = 0; t < 16; t++) W[t] = 32'h0;
    W[0] = 32'h61626380;
    W[15] = 32'h00000018;
    for (int t = 16; t < 64; t++)
      W[t] = ssig1(W[t-2]) + W[t-7] + ssig0(W[t-15]) + W[t-16];
    for (int i = 0; i < 8; i++) begin
`ifdef SHA_FEEDFORWARD_EN
      expv[i] = DIG[i];
`else
      expv[i] = DIG[i] - IV[i];
`endif
    end
    test_reset();
    test_load_iv();
    test_one_round();
    test_full_block();
    test_ignore_busy();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
